mem_store_buffer: RTL
=====================

# mem_store_buffer

Registered store buffer between the store-data shifter and the data-memory port of the RV64 FPGA core. Accepts byte-lane-aligned store requests (data already shifted, strobe already formed) in a single cycle. Queues them in a small in-order FIFO and drains them to memory over a valid/ready handshake. Flags loads that hit a pending store so the core stalls until the conflicting store has drained.

## Interface
- DATA_WIDTH, 64, store data width; must be 64.
- ADDR_WIDTH, 64, byte address width.
- DEPTH, 4, number of entries; power of two, ≥2.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_mem_write_req  in  1  store request from the shifter.
- i_addr  in  ADDR_WIDTH  store byte address.
- i_data  in  DATA_WIDTH  lane-aligned store data.
- i_write_strobe  in  8  byte-lane enables.
- o_full  out  1  buffer full; a store presented now is not accepted.
- o_empty  out  1  no pending stores; fence/flush condition.
- i_load_req  in  1  load being issued this cycle.
- i_load_addr  in  ADDR_WIDTH  load byte address.
- o_load_hazard  out  1  load hits a pending store's doubleword.
- o_mem_valid  out  1  head entry presented to memory.
- o_mem_addr  out  ADDR_WIDTH  head address, bits [2:0] forced to 0.
- o_mem_data  out  DATA_WIDTH  head data.
- o_mem_strobe  out  8  head strobe.
- i_mem_ready  in  1  memory accepts the head entry.

## Operation
- Storage:
  - DEPTH entries of {addr, data, strobe}.
  - Write pointer, read pointer, count of width $clog2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- Push: occurs when i_mem_write_req && !o_full && i_write_strobe != 0.
  - A request with zero strobe is dropped silently; no state change.
- Pop: occurs when o_mem_valid && i_mem_ready.
- Simultaneous push and pop: both happen; count is unchanged.
- o_full = (count == DEPTH), from count only.
  - A pop in the same cycle does not free a slot for a push when full.
  - There is no combinational path from i_mem_ready to o_full.
- Upstream rule: the requester holds the store and retries while o_full is high.
- o_empty = (count == 0); o_mem_valid = !o_empty.
- Memory side is driven combinationally from the head entry register.
  - Payload is stable while valid is high and not yet accepted.
- Hazard:
  - o_load_hazard = i_load_req && a valid entry exists whose addr[ADDR_WIDTH-1:3] equals i_load_addr[ADDR_WIDTH-1:3].
  - The check is conservative: strobe overlap is ignored.
  - A store being pushed in the same cycle is not checked.
  - The core never issues a load and a store in the same cycle.
- Reset:
  - count, pointers and all entry fields are cleared to 0.
  - Reset is applied whenever asserted, including mid-drain; pending stores are discarded.
  - Values after reset: o_full=0, o_empty=1, o_mem_valid=0, o_mem_addr=0, o_mem_data=0, o_mem_strobe=0, o_load_hazard=0.

## Timing
- Push-to-memory latency: a store pushed at edge N appears on o_mem_valid after edge N (next cycle) when the buffer was empty.
- Throughput: one push and one pop per cycle sustained.
- o_load_hazard is combinational and valid in the same cycle as i_load_req.
- Hazard release: clears in the cycle after the pop edge of the last matching entry.
- o_full and o_empty change only after clock edges.

## Structure
- mem_pkg holds:
  - store_entry_t packed struct {addr, data, strobe}.
  - localparam DWORD_LSB = 3.
  - localparam STRB_WIDTH = DATA_WIDTH/8.
- Sub-module sync_fifo: generic DEPTH×WIDTH register FIFO.
  - Ports: push, pop, full, empty, head, plus a flattened entry-valid vector and entry array for the hazard compare.
- Top level holds the zero-strobe filter, address alignment and the DEPTH-way parallel comparator.

## Test plan
- Single store, addr 0x1003, data 0xAB<<24, strobe 0x08, i_mem_ready=1 → next cycle o_mem_valid=1, o_mem_addr=0x1000, o_mem_strobe=0x08; o_empty=1 one cycle later.
- Four stores with i_mem_ready=0 → o_full=1 after the 4th. A 5th store (held) is not accepted until one cycle after the first pop. Drain order matches issue order.
- Store to 0x2008 pending, load from 0x200C → o_load_hazard=1. Load from 0x2010 → 0. Pulse i_mem_ready → hazard drops the next cycle.
- Simultaneous push and pop at count=2 → count stays 2, order preserved. Store with strobe 0x00 → o_empty stays 1.
- Reset asserted with 3 entries pending and i_mem_ready toggling → next cycle o_empty=1, o_mem_valid=0, all memory outputs 0, o_load_hazard=0 for any load.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory store buffer.
package mem_pkg;
  localparam int MEM_DATA_WIDTH = 64;
  localparam int MEM_ADDR_WIDTH = 64;
  localparam int DWORD_LSB      = 3;
  localparam int STRB_WIDTH     = MEM_DATA_WIDTH / 8;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [MEM_DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0]     strobe;
  } store_entry_t;

  function automatic logic [MEM_ADDR_WIDTH-1:0] dword_align(input logic [MEM_ADDR_WIDTH-1:0] a);
    return {a[MEM_ADDR_WIDTH-1:DWORD_LSB], {DWORD_LSB{1'b0}}};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Generic register FIFO that also exposes every slot and its occupancy
// so the owner can run parallel compares against pending entries.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic                   full,
  output logic                   empty,
  output logic [WIDTH-1:0]       head,
  output logic [DEPTH-1:0]       entry_vld,
  output logic [DEPTH*WIDTH-1:0] entries
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] off;
    assign off          = PTR_W'(i) - rd_ptr;
    assign entry_vld[i] = ({1'b0, off} < count);
    assign entries[i*WIDTH +: WIDTH] = mem[i];
  end
endmodule

// File: rtl/mem_store_buffer.sv
// Store buffer between the store shifter and the data-memory port:
// in-order queue, valid/ready drain, doubleword load-hazard detect.
module mem_store_buffer
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mem_write_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [7:0]            i_write_strobe,
  output logic                  o_full,
  output logic                  o_empty,
  input  logic                  i_load_req,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  output logic                  o_load_hazard,
  output logic                  o_mem_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [7:0]            o_mem_strobe,
  input  logic                  i_mem_ready
);
  localparam int EW = $bits(store_entry_t);

  store_entry_t            wr_entry, head_entry;
  logic [DEPTH-1:0]        entry_vld, hit;
  logic [DEPTH*EW-1:0]     entries_flat;
  logic                    push, pop;

  // Zero-strobe requests carry no bytes and are dropped before the queue.
  assign push = i_mem_write_req && !o_full && (i_write_strobe != '0);
  assign pop  = o_mem_valid && i_mem_ready;

  assign wr_entry.addr   = i_addr;
  assign wr_entry.data   = i_data;
  assign wr_entry.strobe = i_write_strobe;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .pop       (pop),
    .wdata     (wr_entry),
    .full      (o_full),
    .empty     (o_empty),
    .head      (head_entry),
    .entry_vld (entry_vld),
    .entries   (entries_flat)
  );

  assign o_mem_valid  = !o_empty;
  assign o_mem_addr   = dword_align(head_entry.addr);
  assign o_mem_data   = head_entry.data;
  assign o_mem_strobe = head_entry.strobe;

  // Conservative: any live store in the same doubleword stalls the load.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    store_entry_t ent;
    assign ent    = entries_flat[i*EW +: EW];
    assign hit[i] = entry_vld[i] &&
                    (ent.addr[ADDR_WIDTH-1:DWORD_LSB] == i_load_addr[ADDR_WIDTH-1:DWORD_LSB]);
  end

  assign o_load_hazard = i_load_req && (|hit);
endmodule
